a1339_spi_responder: RTL and testbench

A1339_SPI_RESPONDER -- requirements
Module: a1339_spi_responder

---
 rtl/a1339_spi_responder.sv | 142 ++++++++++++++
 tb/tb_a1339_spi_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/a1339_spi_responder.sv
// SPI mode-3 responder that emulates an A1339 angle sensor: register reads, zero-offset writes,
// and a response pipelined one frame behind the command that produced it.
module a1339_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] ID_VALUE    = 16'h1339
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    input  logic [11:0] angle_i,
    input  logic [11:0] turns_i,
    output logic [11:0] zero_offset_o,
    output logic        frame_done_o,
    output logic        frame_error_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sck_d, r_ss_d;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_armed;
    logic [4:0]             r_cnt;
    logic [15:0]            r_tx, r_rx, r_pending;
    logic [11:0]            r_offset;
    logic                   r_decode;

    logic        w_sck, w_ss, w_mosi;
    logic        w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic        w_load, w_err, w_last;
    logic [11:0] w_angle_rel;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sck_sync  <= '1;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b1;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync[0]  <= sck_i;
            r_ss_sync[0]   <= ss_n_i;
            r_mosi_sync[0] <= mosi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sck_sync[i]  <= r_sck_sync[i-1];
                r_ss_sync[i]   <= r_ss_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_sck_d <= w_sck;
            r_ss_d  <= w_ss;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_ss_rise  = w_ss & ~r_ss_d;
    assign w_ss_fall  = ~w_ss & r_ss_d;

    assign w_load = (r_state == IDLE) && w_ss_fall && r_armed;
    assign w_err  = (r_state == ACTIVE) && w_ss_rise;
    assign w_last = (r_state == ACTIVE) && !w_ss_rise && w_sck_rise && (r_cnt == 5'd15);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next = ACTIVE;
            ACTIVE:  if (w_ss_rise) w_next = IDLE;
                     else if (w_last) w_next = DRAIN;
            DRAIN:   if (w_ss_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    assign w_angle_rel = angle_i - r_offset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld         <= '0;
            r_armed       <= 1'b0;
            r_cnt         <= '0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_pending     <= 16'hFFFF;
            r_offset      <= '0;
            r_decode      <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            // Arm only once the synchronizer holds real pin samples and ss_n is high,
            // so a frame cut by reset is never picked up halfway through.
            r_vld <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            if (r_vld[SYNC_STAGES] && r_ss_d) r_armed <= 1'b1;
            frame_done_o  <= 1'b0;
            frame_error_o <= w_err;
            r_decode      <= w_last;
            if (w_load) begin
                r_cnt <= '0;
                r_tx  <= r_pending;
            end else if (r_state == ACTIVE && !w_ss_rise) begin
                // Bit 15 is already on miso after the load, so the first falling edge keeps it.
                if (w_sck_fall && r_cnt != 5'd0) r_tx <= {r_tx[14:0], 1'b0};
                if (w_sck_rise) begin
                    r_rx  <= {r_rx[14:0], w_mosi};
                    r_cnt <= r_cnt + 5'd1;
                end
            end
            if (r_decode) begin
                frame_done_o <= 1'b1;
                if (r_rx[15]) begin
                    if (r_rx[14:8] == 7'h1E) r_offset[7:0]  <= r_rx[7:0];
                    if (r_rx[14:8] == 7'h1F) r_offset[11:8] <= r_rx[3:0];
                    r_pending <= 16'h0000;
                end else begin
                    case (r_rx[14:8])
                        7'h20:   r_pending <= {~^w_angle_rel, 3'b000, w_angle_rel};
                        7'h28:   r_pending <= {~^turns_i, 3'b000, turns_i};
                        7'h7F:   r_pending <= ID_VALUE;
                        default: r_pending <= 16'hFFFF;
                    endcase
                end
            end
        end
    end

    assign miso_o        = (r_state == DRAIN) ? 1'b0 : r_tx[15];
    assign miso_oe_o     = ~w_ss;
    assign zero_offset_o = r_offset;

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Directed bench: an SPI master drives frames, a reference model predicts each response
// into a queue, and the word clocked back on miso is popped and compared.
module tb_a1339_spi_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck_i = 1'b1;
    logic        ss_n_i = 1'b1;
    logic        mosi_i = 1'b0;
    logic        miso_o, miso_oe_o;
    logic [11:0] angle_i = '0;
    logic [11:0] turns_i = '0;
    logic [11:0] zero_offset_o;
    logic        frame_done_o, frame_error_o;

    a1339_spi_responder #(.SYNC_STAGES(2), .ID_VALUE(16'h1339)) dut (
        .clock(clock), .reset(reset), .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .angle_i(angle_i), .turns_i(turns_i),
        .zero_offset_o(zero_offset_o), .frame_done_o(frame_done_o), .frame_error_o(frame_error_o)
    );

    always #5 clock = ~clock;

    int          checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_pending = 16'hFFFF;
    logic [11:0] m_off = '0;

    always @(negedge clock) begin
        if (frame_done_o)  done_cnt++;
        if (frame_error_o) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_cmd(input logic [15:0] cmd);
        logic [11:0] v;
        if (cmd[15]) begin
            if (cmd[14:8] == 7'h1E) m_off[7:0]  = cmd[7:0];
            if (cmd[14:8] == 7'h1F) m_off[11:8] = cmd[3:0];
            m_pending = 16'h0000;
        end else begin
            case (cmd[14:8])
                7'h20: begin v = angle_i - m_off; m_pending = {($countones(v) % 2 == 0), 3'b000, v}; end
                7'h28: begin v = turns_i;         m_pending = {($countones(v) % 2 == 0), 3'b000, v}; end
                7'h7F: m_pending = 16'h1339;
                default: m_pending = 16'hFFFF;
            endcase
        end
    endtask

    // Mode 3 master: mosi changes on the falling edge, miso is sampled just before the rising edge.
    task automatic spi_xfer(input logic [15:0] cmd, input int nbits, input bit release_ss,
                            output logic [19:0] rx);
        rx = '0;
        ss_n_i = 1'b0;
        wclk(8);
        for (int i = 0; i < nbits; i++) begin
            sck_i  = 1'b0;
            mosi_i = (i < 16) ? cmd[15-i] : 1'b0;
            wclk(8);
            rx = {rx[18:0], miso_o};
            sck_i = 1'b1;
            wclk(8);
        end
        wclk(4);
        if (release_ss) begin
            ss_n_i = 1'b1;
            wclk(10);
        end
    endtask

    task automatic full_frame(input logic [15:0] cmd, input string tag, output logic [15:0] word);
        logic [19:0] rx;
        logic [15:0] exp;
        int d0;
        d0 = done_cnt;
        exp_q.push_back(m_pending);
        spi_xfer(cmd, 16, 1'b1, rx);
        model_cmd(cmd);
        word = rx[15:0];
        exp = exp_q.pop_front();
        check(tag, 32'(word), 32'(exp));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        logic [19:0] rx;
        logic [15:0] exp;
        int e0, d0;

        wclk(4);
        check("rst_miso", 32'(miso_o), 32'd0);
        check("rst_oe", 32'(miso_oe_o), 32'd0);
        check("rst_offset", 32'(zero_offset_o), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_error", 32'(frame_error_o), 32'd0);
        reset = 1'b0;
        wclk(10);

        angle_i = 12'h123;
        full_frame(16'h2000, "rd_angle_cmd", w);
        check("first_resp_ffff", 32'(w), 32'hFFFF);
        full_frame(16'h0000, "rd_angle_resp", w);
        check("angle_8123", 32'(w), 32'h8123);

        full_frame(16'h9E10, "wr_off_lo", w);
        full_frame(16'h9F00, "wr_off_hi", w);
        check("offset_010", 32'(zero_offset_o), 32'h010);
        angle_i = 12'h005;
        full_frame(16'h2000, "rd_wrap_cmd", w);
        check("write_resp_0000", 32'(w), 32'h0000);
        full_frame(16'h7F00, "rd_id_cmd", w);
        check("wrap_8ff5", 32'(w), 32'h8FF5);
        full_frame(16'h5500, "rd_unk_cmd", w);
        check("id_1339", 32'(w), 32'h1339);
        full_frame(16'h0000, "rd_unk_resp", w);
        check("unknown_ffff", 32'(w), 32'hFFFF);

        turns_i = 12'hABC;
        full_frame(16'h2800, "rd_turns_cmd", w);
        full_frame(16'h7F00, "rd_turns_resp", w);
        check("turns_0abc", 32'(w), 32'h0ABC);

        e0 = err_cnt; d0 = done_cnt;
        spi_xfer(16'h9E55, 9, 1'b1, rx);
        check("abort_error_pulse", 32'(err_cnt - e0), 32'd1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_offset_kept", 32'(zero_offset_o), 32'h010);
        full_frame(16'h0000, "after_abort", w);
        check("abort_prev_resp", 32'(w), 32'h1339);

        d0 = done_cnt;
        exp_q.push_back(m_pending);
        spi_xfer(16'h2000, 20, 1'b1, rx);
        model_cmd(16'h2000);
        exp = exp_q.pop_front();
        check("long_word", 32'(rx[19:4]), 32'(exp));
        check("long_tail_zero", 32'(rx[3:0]), 32'd0);
        check("long_one_done", 32'(done_cnt - d0), 32'd1);
        full_frame(16'h0000, "after_long", w);
        check("long_decoded", 32'(w), 32'h8FF5);

        spi_xfer(16'h7F00, 8, 1'b0, rx);
        reset = 1'b1;
        wclk(3);
        check("midrst_miso", 32'(miso_o), 32'd0);
        check("midrst_oe", 32'(miso_oe_o), 32'd0);
        reset = 1'b0;
        m_pending = 16'hFFFF;
        m_off = '0;
        e0 = err_cnt; d0 = done_cnt;
        spi_xfer(16'hFFFF, 8, 1'b0, rx);
        check("midrst_silent", 32'(rx[7:0]), 32'd0);
        ss_n_i = 1'b1;
        wclk(10);
        check("midrst_no_error", 32'(err_cnt - e0), 32'd0);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_offset", 32'(zero_offset_o), 32'd0);
        full_frame(16'h2000, "post_rst_cmd", w);
        check("post_rst_ffff", 32'(w), 32'hFFFF);
        full_frame(16'h0000, "post_rst_resp", w);
        check("post_rst_8005", 32'(w), 32'h8005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
